ula_arbiter: RTL

- Shares one 8-bit ULA between two requesters (port 0, port 1) using round-robin arbitration.
- Accepts an operation from a requester through a valid/ready handshake and drives a/b/opcode to the ULA.
- Waits LATENCY cycles, captures the 9-bit result, then returns it to the requester that issued it through a valid/ready response handshake.
- Sits between the requesting logic and the ULA instance; it is the only block that drives the ULA inputs.

---
 rtl/ula_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - round-robin arbiter sharing one ULA between two requesters
// Accepts one operation at a time, waits LATENCY cycles, returns the result to its issuer.
module ula_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_op,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [8:0] rsp0_s,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_op,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [8:0] rsp1_s,
  output logic [7:0] ula_a,
  output logic [7:0] ula_b,
  output logic [2:0] ula_op,
  input  logic [8:0] ula_s,
  output logic       busy,
  output logic       grant
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_grant;
  logic [3:0] r_cnt;
  logic [7:0] r_ula_a;
  logic [7:0] r_ula_b;
  logic [2:0] r_ula_op;
  logic [8:0] r_rsp0_s;
  logic [8:0] r_rsp1_s;
  logic       w_idle;
  logic       w_acc0;
  logic       w_acc1;
  logic       w_accept;
  logic       w_done;
  logic       w_rsp_hs;

  assign w_idle     = (r_state == S_IDLE);
  // r_grant doubles as last_grant: on contention the other requester is served
  assign req0_ready = w_idle & req0_valid & (~req1_valid | r_grant);
  assign req1_ready = w_idle & req1_valid & (~req0_valid | ~r_grant);
  assign w_acc0     = req0_valid & req0_ready;
  assign w_acc1     = req1_valid & req1_ready;
  assign w_accept   = w_acc0 | w_acc1;
  assign w_done     = (r_state == S_EXEC) & (r_cnt == 4'd0);
  assign w_rsp_hs   = (r_state == S_RESP) & (r_grant ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  if (w_done)   w_next = S_RESP;
      S_RESP:  if (w_rsp_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant  <= 1'b1;
      r_cnt    <= 4'd0;
      r_ula_a  <= 8'd0;
      r_ula_b  <= 8'd0;
      r_ula_op <= 3'd0;
      r_rsp0_s <= 9'd0;
      r_rsp1_s <= 9'd0;
    end else begin
      if (w_accept) begin
        r_ula_a  <= w_acc1 ? req1_a  : req0_a;
        r_ula_b  <= w_acc1 ? req1_b  : req0_b;
        r_ula_op <= w_acc1 ? req1_op : req0_op;
        r_grant  <= w_acc1;
        r_cnt    <= LAT_M1;
      end else if ((r_state == S_EXEC) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done) begin
        if (r_grant) r_rsp1_s <= ula_s;
        else         r_rsp0_s <= ula_s;
      end
    end
  end

  assign rsp0_valid = (r_state == S_RESP) & ~r_grant;
  assign rsp1_valid = (r_state == S_RESP) & r_grant;
  assign rsp0_s     = r_rsp0_s;
  assign rsp1_s     = r_rsp1_s;
  assign ula_a      = r_ula_a;
  assign ula_b      = r_ula_b;
  assign ula_op     = r_ula_op;
  assign busy       = ~w_idle;
  assign grant      = r_grant;
endmodule
